// File: rtl/interp_sched_pkg.sv
// Shared types and constants for the interpolator sequencing controller:
// controller states, interpolation mode encodings and the mode-to-period map.
package interp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_e;

    localparam logic [2:0] MODE_X1    = 3'd0;
    localparam logic [2:0] MODE_X10   = 3'd1;
    localparam logic [2:0] MODE_X100  = 3'd2;
    localparam logic [2:0] MODE_X1000 = 3'd3;

    localparam int DEF_PERIOD1     = 10;
    localparam int DEF_PERIOD2     = 100;
    localparam int DEF_PERIOD3     = 1000;
    localparam int DEF_CNT_W       = 10;
    localparam int DEF_PRIME_STEPS = 2;

    // Unused encodings 4..7 fall back to one clock per sample.
    function automatic int mode_period(input logic [2:0] mode, input int p1,
                                       input int p2, input int p3);
        case (mode)
            MODE_X1:    return 1;
            MODE_X10:   return p1;
            MODE_X100:  return p2;
            MODE_X1000: return p3;
            default:    return 1;
        endcase
    endfunction

endpackage

// File: rtl/interp_period_cnt.sv
// Period counter for the scheduler: counts up to 'last' and parks there
// until cleared, so it can never wrap past the end of a period.
module interp_period_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign terminal = (cnt_q == last);
    assign cnt      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold && !terminal) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interp_scheduler.sv
// Sequencing controller for the interpolator: paces oscillator steps, strobes
// Enable on sample boundaries and applies mode changes only at boundaries.
// Define INTERP_SAMPLE_CNT_EN to add the SampleCnt Enable counter port.
module interp_scheduler
    import interp_sched_pkg::*;
#(
    parameter int PERIOD1     = DEF_PERIOD1,
    parameter int PERIOD2     = DEF_PERIOD2,
    parameter int PERIOD3     = DEF_PERIOD3,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PRIME_STEPS = DEF_PRIME_STEPS
) (
    input  logic       Fg_CLK,
    input  logic       Fg_RESET,
    input  logic       Run,
    input  logic [2:0] ModeReq,
    input  logic       ModeReqValid,
    output logic       ModeReqReady,
    output logic       OscStep,
    input  logic       OscValid,
    output logic [2:0] Mode,
    output logic       Enable,
    output logic       Busy,
    output logic       Underrun
`ifdef INTERP_SAMPLE_CNT_EN
    ,
    output logic [31:0] SampleCnt
`endif
);

    sched_state_e     state_q, state_d;
    logic [2:0]       mode_q, mode_d, pend_mode_q, pend_mode_d, mode_out;
    logic             pend_valid_q, pend_valid_d;
    logic             outstanding_q, outstanding_d;
    logic             got_valid_q, got_valid_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       prime_cnt_q, prime_cnt_d;
    logic [CNT_W-1:0] cnt, cnt_last;
    logic             terminal, boundary, osc_step, enable, ack, ready, accept;

    assign cnt_last = CNT_W'(mode_period(mode_q, PERIOD1, PERIOD2, PERIOD3) - 1);
    assign accept   = ModeReqValid && !pend_valid_q;

    interp_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
        .clk      (Fg_CLK),
        .rst      (Fg_RESET),
        .clr      (boundary || (state_q != RUN)),
        .hold     (state_q != RUN),
        .last     (cnt_last),
        .cnt      (cnt),
        .terminal (terminal)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        mode_out      = mode_q;
        pend_mode_d   = pend_mode_q;
        pend_valid_d  = pend_valid_q;
        got_valid_d   = got_valid_q;
        underrun_d    = underrun_q;
        prime_cnt_d   = prime_cnt_q;
        osc_step      = 1'b0;
        enable        = 1'b0;
        boundary      = 1'b0;
        ack           = 1'b0;
        ready         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    mode_d       = pend_mode_q;
                    pend_valid_d = 1'b0;
                end
                if (Run) begin
                    state_d     = PRIME;
                    prime_cnt_d = '0;
                end
            end
            PRIME: begin
                osc_step = !outstanding_q && Run;
                // A same-cycle OscValid acknowledges the step issued this cycle.
                ack      = OscValid && (outstanding_q || osc_step);
                if (!outstanding_q && !Run) begin
                    state_d = IDLE;
                end else if (ack) begin
                    prime_cnt_d = prime_cnt_q + 8'd1;
                    if (!Run) begin
                        state_d = IDLE;
                    end else if (prime_cnt_q == 8'(PRIME_STEPS - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                osc_step = (cnt == '0) && !outstanding_q && !got_valid_q;
                ack      = OscValid && (outstanding_q || osc_step);
                ready    = got_valid_q || ack;
                if (terminal) begin
                    if (ready) begin
                        boundary    = 1'b1;
                        enable      = 1'b1;
                        got_valid_d = 1'b0;
                        if (pend_valid_q) begin
                            mode_d       = pend_mode_q;
                            mode_out     = pend_mode_q;
                            pend_valid_d = 1'b0;
                        end
                        if (!Run) begin
                            state_d = IDLE;
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else if (ack) begin
                    got_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Slot is empty whenever accept fires, so this never races the clears above.
        if (accept) begin
            if (state_q == IDLE) begin
                mode_d = ModeReq;
            end else begin
                pend_mode_d  = ModeReq;
                pend_valid_d = 1'b1;
            end
        end

        outstanding_d = (outstanding_q || osc_step) && !ack;
    end

    always_ff @(posedge Fg_CLK) begin
        if (Fg_RESET) begin
            state_q       <= IDLE;
            mode_q        <= MODE_X1;
            pend_mode_q   <= MODE_X1;
            pend_valid_q  <= 1'b0;
            outstanding_q <= 1'b0;
            got_valid_q   <= 1'b0;
            underrun_q    <= 1'b0;
            prime_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pend_mode_q   <= pend_mode_d;
            pend_valid_q  <= pend_valid_d;
            outstanding_q <= outstanding_d;
            got_valid_q   <= got_valid_d;
            underrun_q    <= underrun_d;
            prime_cnt_q   <= prime_cnt_d;
        end
    end

    assign ModeReqReady = !pend_valid_q;
    assign OscStep      = osc_step;
    assign Mode         = mode_out;
    assign Enable       = enable;
    assign Busy         = (state_q != IDLE);
    assign Underrun     = underrun_q;

`ifdef INTERP_SAMPLE_CNT_EN
    logic [31:0] sample_cnt_q, sample_cnt_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (state_q == IDLE && state_d == PRIME) begin
            sample_cnt_d = '0;
        end else if (enable) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (Fg_RESET) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign SampleCnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_interp_scheduler.sv
// Bench for interp_scheduler: an oscillator emulator with fixed ack latency,
// an analytic timeline model feeding an Enable scoreboard, and a summary.
module tb_interp_scheduler;

    localparam int PS = 2;

    logic        Fg_CLK = 1'b0;
    logic        Fg_RESET = 1'b1;
    logic        Run = 1'b0;
    logic [2:0]  ModeReq = 3'd0;
    logic        ModeReqValid = 1'b0;
    logic        OscValid = 1'b0;
    logic        ModeReqReady, OscStep, Enable, Busy, Underrun;
    logic [2:0]  Mode;
`ifdef INTERP_SAMPLE_CNT_EN
    logic [31:0] SampleCnt;
`endif

    // Each entry: {cycle of the Enable, Mode seen on that cycle}.
    logic [34:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 0;
    int due = -1;
    int steps_seen = 0;
    int cur_mode = 0;
    bit und_model = 1'b0;

    interp_scheduler dut (
        .Fg_CLK       (Fg_CLK),
        .Fg_RESET     (Fg_RESET),
        .Run          (Run),
        .ModeReq      (ModeReq),
        .ModeReqValid (ModeReqValid),
        .ModeReqReady (ModeReqReady),
        .OscStep      (OscStep),
        .OscValid     (OscValid),
        .Mode         (Mode),
        .Enable       (Enable),
        .Busy         (Busy),
        .Underrun     (Underrun)
`ifdef INTERP_SAMPLE_CNT_EN
        ,
        .SampleCnt    (SampleCnt)
`endif
    );

    always #5 Fg_CLK = ~Fg_CLK;
    always @(posedge Fg_CLK) cyc <= cyc + 1;

    function automatic int p_of(input int m);
        case (m)
            1: return 10;
            2: return 100;
            3: return 1000;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Oscillator emulator: answers each OscStep with OscValid 'lat' cycles later.
    initial forever begin
        @(posedge Fg_CLK);
        #2;
        OscValid = 1'b0;
        if (due == cyc) begin
            OscValid = 1'b1;
            due = -1;
        end
        if (OscStep === 1'b1) begin
            if (lat == 0) OscValid = 1'b1;
            else due = cyc + lat;
        end
    end

    // Monitor: every Enable pops the scoreboard and checks its cycle and Mode.
    initial begin : monitor
        logic [34:0] e;
        forever begin
            @(negedge Fg_CLK);
            if (OscStep === 1'b1) steps_seen++;
            if (Enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_enable: got Enable=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("enable_cycle", 64'(cyc), 64'(e[34:3]));
                    check("enable_mode", 64'(Mode), 64'(e[2:0]));
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_mode"}, 64'(Mode), 64'd0);
        check({tag, "_enable"}, 64'(Enable), 64'd0);
        check({tag, "_oscstep"}, 64'(OscStep), 64'd0);
        check({tag, "_underrun"}, 64'(Underrun), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_ready"}, 64'(ModeReqReady), 64'd1);
`ifdef INTERP_SAMPLE_CNT_EN
        check({tag, "_samplecnt"}, 64'(SampleCnt), 64'd0);
`endif
    endtask

    task automatic do_reset();
        @(posedge Fg_CLK); #1;
        Fg_RESET = 1'b1; Run = 1'b0; ModeReqValid = 1'b0;
        @(posedge Fg_CLK); #1;
        Fg_RESET = 1'b0;
        @(negedge Fg_CLK);
        check_reset_values("reset");
        cur_mode = 0; und_model = 1'b0; exp_q.delete();
    endtask

    task automatic set_mode_idle(input int m);
        @(posedge Fg_CLK); #1;
        ModeReqValid = 1'b1; ModeReq = 3'(m);
        @(negedge Fg_CLK);
        check("idle_req_ready", 64'(ModeReqReady), 64'd1);
        check("idle_mode_before", 64'(Mode), 64'(cur_mode));
        @(posedge Fg_CLK); #1;
        ModeReqValid = 1'b0;
        @(negedge Fg_CLK);
        check("idle_mode_applied", 64'(Mode), 64'(m));
        cur_mode = m;
    endtask

    // Model: prime takes PS*(lat+1) cycles; each period runs from its step at
    // cycle t to a boundary at t + max(P-1, lat); a request applies at the first
    // boundary strictly after its accept cycle; Run low at a boundary ends it.
    task automatic run_segment(input int m_lat, input int n, input int req_k, input int req_off,
                               input int req_mode, input int drop_off);
        int t, b, pm, r, d, m, req_cyc, req_b, req_old, s_last, b_last, steps0, final_mode;
        bit have_req;
        lat = m_lat;
        r = cyc + 1;
        t = r + 1 + PS * (m_lat + 1);
        m = cur_mode; have_req = 1'b0; req_cyc = -10; req_b = -10; req_old = 0;
        s_last = t; b_last = t;
        for (int k = 0; k < n; k++) begin
            pm = p_of(m);
            b = t + ((pm - 1 > m_lat) ? pm - 1 : m_lat);
            if (k == req_k) begin
                req_cyc = t + ((req_off > b - t) ? b - t : req_off);
                req_b = b; req_old = m; have_req = 1'b1;
            end
            if (have_req && req_cyc < b) begin
                m = req_mode; have_req = 1'b0;
            end
            if (m_lat > pm - 1) und_model = 1'b1;
            exp_q.push_back({b[31:0], m[2:0]});
            s_last = t; b_last = b; t = b + 1;
        end
        if (drop_off < 0) d = s_last + int'($urandom_range(b_last - s_last, 0));
        else d = s_last + ((drop_off > b_last - s_last) ? b_last - s_last : drop_off);
        final_mode = have_req ? req_mode : m;
        steps0 = steps_seen;
        for (int c = r; c <= b_last + 3; c++) begin
            @(posedge Fg_CLK); #1;
            Run = (c < d);
            ModeReqValid = (c == req_cyc);
            ModeReq = 3'(req_mode);
            @(negedge Fg_CLK);
            if (c == r + 1) check("busy_prime", 64'(Busy), 64'd1);
            if (c == req_cyc) check("req_ready", 64'(ModeReqReady), 64'd1);
            if (c == req_cyc + 1) check("req_held_ready", 64'(ModeReqReady), 64'd0);
            if (c == req_cyc + 1 && c < req_b) check("mode_hold", 64'(Mode), 64'(req_old));
        end
        check("enables_left", 64'(exp_q.size()), 64'd0);
        check("busy_idle", 64'(Busy), 64'd0);
        check("osc_steps", 64'(steps_seen - steps0), 64'(PS + n));
        check("mode_after", 64'(Mode), 64'(final_mode));
        check("underrun", 64'(Underrun), 64'(und_model));
`ifdef INTERP_SAMPLE_CNT_EN
        check("sample_cnt", 64'(SampleCnt), 64'(n));
`endif
        exp_q.delete();
        cur_mode = final_mode;
    endtask

    task automatic reset_mid_period();
        int r, s, steps0;
        set_mode_idle(1);
        lat = 5;
        r = cyc + 1;
        s = r + 1 + PS * 6;
        for (int c = r; c <= s; c++) begin
            @(posedge Fg_CLK); #1;
            Run = 1'b1;
        end
        @(posedge Fg_CLK); #1;
        Fg_RESET = 1'b1; Run = 1'b0;
        @(posedge Fg_CLK); #1;
        Fg_RESET = 1'b0;
        @(negedge Fg_CLK);
        check_reset_values("rst_mid");
        cur_mode = 0; und_model = 1'b0; exp_q.delete();
        steps0 = steps_seen;
        repeat (12) @(negedge Fg_CLK);
        check("rst_mid_no_steps", 64'(steps_seen - steps0), 64'd0);
        check("rst_mid_busy", 64'(Busy), 64'd0);
        check("rst_mid_mode", 64'(Mode), 64'd0);
    endtask

    initial begin
        int m, n;
        do_reset();
        set_mode_idle(1);
        run_segment(3, 4, -1, 0, 0, -1);
        set_mode_idle(2);
        run_segment(int'($urandom_range(50, 0)), 2, 0, 40, 3, -1);
        set_mode_idle(1);
        run_segment(15, 3, -1, 0, 0, -1);
        do_reset();
        run_segment(0, 6, -1, 0, 0, -1);
        run_segment(2, 5, -1, 0, 0, -1);
        do_reset();
        set_mode_idle(1);
        run_segment(3, 3, -1, 0, 0, 5);
        reset_mid_period();
        run_segment(1, 3, -1, 0, 0, -1);
        for (int i = 0; i < 6; i++) begin
            m = int'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) set_mode_idle(m);
            n = (p_of(cur_mode) >= 1000) ? 2 : int'($urandom_range(4, 2));
            run_segment(int'($urandom_range(20, 0)), n, int'($urandom_range(n, 0)),
                        int'($urandom_range(120, 0)), int'($urandom_range(3, 0)), -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interp_scheduler.md
Name: interp_scheduler

Overview:
Sequencing controller for the function-generator interpolator datapath. It paces the sine oscillator with one-sample step requests and acknowledges, and strobes the interpolator Enable at each sample boundary. It drives the interpolator Mode so that the oversampling ratio (1/10/100/1000 clocks per oscillator sample) matches the fractional-step gain. It also primes the oscillator history and applies mode changes only at sample boundaries.

Parameters:
PERIOD1, 10, clocks per oscillator sample in Mode 1
PERIOD2, 100, clocks per oscillator sample in Mode 2
PERIOD3, 1000, clocks per oscillator sample in Mode 3
CNT_W, 10, period counter width; must hold PERIOD3-1
PRIME_STEPS, 2, oscillator steps issued before RUN so that Y[n-1] and Y[n-2] are valid

Ports:
Fg_CLK  in  1  function-generator clock; single clock domain
Fg_RESET  in  1  synchronous, active-high reset
Run  in  1  level; 1 = generate waveform, 0 = stop at next boundary
ModeReq  in  3  requested interpolation mode
ModeReqValid  in  1  mode request valid
ModeReqReady  out  1  mode request accepted when Valid&Ready
OscStep  out  1  one-cycle pulse: oscillator advance one sample
OscValid  in  1  one-cycle pulse: oscillator new sample ready (ack of OscStep)
Mode  out  3  to interpolator Mode
Enable  out  1  one-cycle pulse to interpolator: new sample boundary
Busy  out  1  state != IDLE
Underrun  out  1  sticky: OscValid missing at a boundary
SampleCnt  out  32  Enable count (optional feature only)

Behaviour:
- Reset (any state, including mid-period): state=IDLE; Mode=0; Enable=0; OscStep=0; Underrun=0; outstanding=0; pending-mode empty; cnt=0; ModeReqReady=1.
- Period P(Mode): 1->PERIOD1, 2->PERIOD2, 3->PERIOD3, 0 and 4..7 -> 1.
- Outstanding flag: set on an OscStep, cleared on OscValid. At most one step is outstanding. OscValid while not outstanding is ignored.
- IDLE: outputs quiet. A Run=1 sample moves to PRIME with prime count=0.
- PRIME: issue an OscStep, wait for OscValid, and repeat PRIME_STEPS times. No Enable. Then go to RUN with cnt=0. Run dropping during PRIME goes to IDLE after the outstanding ack returns.
- RUN, cnt==0 and not outstanding: OscStep=1 this cycle.
- RUN, counting: cnt increments each cycle up to P-1.
- RUN, boundary (cnt==P-1 and sample ready = got-valid or OscValid this cycle):
  - Enable=1 for one cycle and cnt->0.
  - A pending mode, if present, drives Mode from this same cycle; the new P applies to the next period.
  - If Run=0, go to IDLE instead, still issuing this final Enable.
- RUN, cnt==P-1 with no sample ready: hold cnt, set Underrun (sticky until reset). Assert Enable in the cycle OscValid arrives. There is no timeout.
- P==1: cnt stays at 0. OscStep and Enable coincide when OscValid returns in the same cycle. Throughput is one Enable per oscillator round trip.
- Mode handshake:
  - ModeReqReady=1 when the pending slot is empty.
  - Accept stores ModeReq in the slot. In IDLE it applies to Mode immediately on the next cycle.
  - A request accepted in the same cycle as a boundary is held for the next boundary.
- Downstream timing: the interpolator registers N and Enable one cycle later, so Mode changes exactly on the Enable cycle, never mid-period.
- cnt never wraps past P-1. A Mode change cannot truncate the current period.

Optional Feature:
INTERP_SAMPLE_CNT_EN:
- Defined: SampleCnt port exists. It is a 32-bit count of Enable pulses, cleared on reset and on IDLE->PRIME, and wraps modulo 2^32.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package interp_sched_pkg: state enum (IDLE, PRIME, RUN), mode encodings (MODE_X1=0, MODE_X10=1, MODE_X100=2, MODE_X1000=3), default period constants, and a function mapping mode to period.
- Sub-module interp_period_cnt: loadable CNT_W counter with hold input and terminal flag (cnt==P-1). The FSM, handshakes and mode slot stay in interp_scheduler.

Test Plan:
- Reset, Run=1, ModeReq=1 accepted in IDLE, OscValid 3 cycles after each OscStep -> exactly 2 prime steps, then Enable every 10 clocks; Mode=1; Underrun=0.
- Mode=2 running; ModeReq=3 at cnt=40 -> Mode stays 2 until the Enable at cnt=99; next Enable 1000 clocks later; ModeReqReady low until the boundary.
- Mode=1, OscValid delayed to 15 cycles after OscStep -> cnt holds at 9; Enable on the OscValid cycle; Underrun=1 and stays 1.
- Mode=0, OscValid same cycle as OscStep -> Enable every clock; with 2-cycle ack latency -> Enable every 3 clocks.
- Run dropped at cnt=5 in Mode 1 -> final Enable at cnt=9, then IDLE, Busy=0, no further OscStep.
- Fg_RESET asserted mid-period with a step outstanding -> next cycle all outputs at reset values; a late OscValid is ignored; with INTERP_SAMPLE_CNT_EN, SampleCnt=0.
